// File: rtl/mem_arbiter.sv
// Shares one single-outstanding bus between fetch (IF) and data (MEM) requesters; MEM has priority
// unless MEM_ARB_STARVE_GUARD_EN is defined. Bus request 1 cycle after arbitration; responses pass through combinationally.

module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_resp_valid,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_mem_q, owner_mem_d;
    logic                discard_q, discard_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;

    logic                if_elig;
    logic                if_prio;
    logic                grant_if;
    logic                grant_mem;

    // A flushing fetch is not a candidate, even in the cycle it is still asserted.
    assign if_elig = if_req && !if_flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign if_prio = (starve_q == 4'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if ((state_q == S_IDLE) && !if_req) begin
            starve_d = '0;
        end else if (grant_mem && if_elig && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_prio = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        discard_d   = discard_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;

        case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                if (mem_req && !(if_prio && if_elig)) begin
                    grant_mem   = 1'b1;
                    state_d     = S_ADDR;
                    owner_mem_d = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wstrb_d = mem_wstrb;
                end else if (if_elig) begin
                    grant_if    = 1'b1;
                    state_d     = S_ADDR;
                    owner_mem_d = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_wstrb_d = '0;
                end
            end
            S_ADDR: begin
                if (if_flush && !owner_mem_q) begin
                    discard_d = 1'b1;
                end
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (if_flush && !owner_mem_q) begin
                    discard_d = 1'b1;
                end
                // The discard flag only lives for the abandoned transaction.
                if (bus_rvalid) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            discard_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            discard_q   <= discard_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
        end
    end

    // A flush arriving with the response still swallows it.
    assign if_resp_valid  = (state_q == S_WAIT) && !owner_mem_q && bus_rvalid
                            && !discard_q && !if_flush;
    assign mem_resp_valid = (state_q == S_WAIT) && owner_mem_q && bus_rvalid;
    assign if_rdata       = bus_rdata;
    assign mem_rdata      = bus_rdata;

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, priority, flush, stall, starvation order, reset mid-transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_wstrb;

    int vectors    = 0;
    int miscompares = 0;
    logic exp_mem [6];

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 4ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;

        // Reset state
        step(); step(); settle();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_if_resp", if_resp_valid, 0);
        chk("rst_mem_resp", mem_resp_valid, 0);
        step(); rst = 1'b1;

        // Single fetch: request N, gnt N+1, rvalid N+3
        step(); if_req = 1; if_addr = 64'h1000; settle();
        chk("f1_req_n", bus_req, 0);
        step(); bus_gnt = 1; settle();
        chk("f1_req_n1", bus_req, 1);
        chk("f1_addr", bus_addr, 64'h1000);
        chk("f1_we", bus_we, 0);
        step(); bus_gnt = 0; settle();
        chk("f1_req_n2", bus_req, 0);
        chk("f1_resp_n2", if_resp_valid, 0);
        step(); bus_rvalid = 1; bus_rdata = 64'h13; settle();
        chk("f1_resp", if_resp_valid, 1);
        chk("f1_rdata", if_rdata, 64'h13);
        chk("f1_mresp", mem_resp_valid, 0);
        step(); bus_rvalid = 0; if_req = 0; settle();
        chk("f1_resp_off", if_resp_valid, 0);
        chk("f1_req_off", bus_req, 0);

        // Simultaneous: MEM write first, then IF
        step(); if_req = 1; if_addr = 64'h1008;
        mem_req = 1; mem_we = 1; mem_addr = 64'h2000; mem_wdata = 64'hDEADBEEF; mem_wstrb = 8'hFF;
        settle();
        step(); bus_gnt = 1; settle();
        chk("sim_req", bus_req, 1);
        chk("sim_we", bus_we, 1);
        chk("sim_addr", bus_addr, 64'h2000);
        chk("sim_wstrb", bus_wstrb, 8'hFF);
        chk("sim_wdata", bus_wdata, 64'hDEADBEEF);
        step(); bus_gnt = 0; bus_rvalid = 1; settle();
        chk("sim_mresp", mem_resp_valid, 1);
        chk("sim_iresp", if_resp_valid, 0);
        step(); bus_rvalid = 0; mem_req = 0; mem_we = 0; settle();
        chk("sim_idle_req", bus_req, 0);
        step(); bus_gnt = 1; settle();
        chk("sim_if_req", bus_req, 1);
        chk("sim_if_addr", bus_addr, 64'h1008);
        chk("sim_if_we", bus_we, 0);
        chk("sim_if_wstrb", bus_wstrb, 0);
        step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h55; settle();
        chk("sim_if_resp", if_resp_valid, 1);
        chk("sim_if_rdata", if_rdata, 64'h55);
        step(); bus_rvalid = 0; if_req = 0;

        // Flush while waiting, then a fresh fetch at 0x3000
        step(); if_req = 1; if_addr = 64'h1010; settle();
        step(); bus_gnt = 1; settle();
        chk("fl_req", bus_req, 1);
        step(); bus_gnt = 0; if_flush = 1; if_req = 0; settle();
        chk("fl_resp_a", if_resp_valid, 0);
        step(); if_flush = 0; if_req = 1; if_addr = 64'h3000; settle();
        chk("fl_no_issue", bus_req, 0);
        step(); bus_rvalid = 1; bus_rdata = 64'hBAD; settle();
        chk("fl_swallow", if_resp_valid, 0);
        chk("fl_mresp", mem_resp_valid, 0);
        step(); bus_rvalid = 0; settle();
        chk("fl_idle_req", bus_req, 0);
        step(); bus_gnt = 1; settle();
        chk("fl_new_req", bus_req, 1);
        chk("fl_new_addr", bus_addr, 64'h3000);
        step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h77; settle();
        chk("fl_new_resp", if_resp_valid, 1);
        chk("fl_new_rdata", if_rdata, 64'h77);
        step(); bus_rvalid = 0; if_req = 0;

        // Flush in the same cycle as the response
        step(); if_req = 1; if_addr = 64'h4000; settle();
        step(); bus_gnt = 1; settle();
        step(); bus_gnt = 0; bus_rvalid = 1; if_flush = 1; if_req = 0; settle();
        chk("fl_same_cycle", if_resp_valid, 0);
        step(); bus_rvalid = 0; if_flush = 0;

        // Stray gnt/rvalid in IDLE are ignored
        step(); bus_gnt = 1; bus_rvalid = 1; settle();
        chk("stray_iresp", if_resp_valid, 0);
        chk("stray_mresp", mem_resp_valid, 0);
        step(); bus_gnt = 0; bus_rvalid = 0; settle();
        chk("stray_req", bus_req, 0);

        // Bus stall: gnt low for 5 cycles
        step(); mem_req = 1; mem_we = 0; mem_addr = 64'h5000; mem_wstrb = 8'h00; settle();
        for (int i = 0; i < 5; i++) begin
            step(); settle();
            chk("stall_req", bus_req, 1);
            chk("stall_addr", bus_addr, 64'h5000);
        end
        step(); bus_gnt = 1; settle();
        chk("stall_req_gnt", bus_req, 1);
        step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h99; settle();
        chk("stall_req_wait", bus_req, 0);
        chk("stall_mresp", mem_resp_valid, 1);
        chk("stall_mrdata", mem_rdata, 64'h99);
        step(); bus_rvalid = 0; mem_req = 0; settle();
        chk("stall_one_txn", bus_req, 0);

        // Both requesters held: grant order
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_mem = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        step(); mem_req = 1; mem_we = 1; mem_addr = 64'h2100; mem_wstrb = 8'h0F;
        if_req = 1; if_addr = 64'h1100; settle();
        for (int k = 0; k < 6; k++) begin
            step(); bus_gnt = 1; settle();
            chk("stv_req", bus_req, 1);
            chk("stv_owner_we", bus_we, exp_mem[k]);
            step(); bus_gnt = 0; bus_rvalid = 1; settle();
            chk("stv_mresp", mem_resp_valid, exp_mem[k]);
            chk("stv_iresp", if_resp_valid, !exp_mem[k]);
            step(); bus_rvalid = 0;
            if (k == 5) begin
                mem_req = 0; if_req = 0;
            end
            settle();
        end

        // Asynchronous reset in WAIT
        step(); mem_req = 1; mem_we = 1; mem_addr = 64'h6000; mem_wdata = 64'h1234; mem_wstrb = 8'h0F; settle();
        step(); bus_gnt = 1; settle();
        step(); bus_gnt = 0; bus_rvalid = 1; settle();
        chk("rw_addr_pre", bus_addr, 64'h6000);
        chk("rw_mresp_pre", mem_resp_valid, 1);
        rst = 1'b0;
        #1;
        chk("rw_req", bus_req, 0);
        chk("rw_we", bus_we, 0);
        chk("rw_addr", bus_addr, 0);
        chk("rw_wdata", bus_wdata, 0);
        chk("rw_wstrb", bus_wstrb, 0);
        chk("rw_mresp", mem_resp_valid, 0);
        chk("rw_iresp", if_resp_valid, 0);
        step(); bus_rvalid = 0; mem_req = 0; mem_we = 0;
        step(); rst = 1'b1;
        step(); mem_req = 1; mem_addr = 64'h7000; settle();
        chk("rw_idle", bus_req, 0);
        step(); bus_gnt = 1; settle();
        chk("rw_new_req", bus_req, 1);
        chk("rw_new_addr", bus_addr, 64'h7000);
        chk("rw_new_we", bus_we, 0);
        step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'hABCD; settle();
        chk("rw_new_resp", mem_resp_valid, 1);
        chk("rw_new_rdata", mem_rdata, 64'hABCD);
        step(); bus_rvalid = 0; mem_req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-outstanding memory bus between the instruction-fetch requester (`stage_if`) and the data requester (`stage_mem`). It serialises their transactions and routes each response back to its owner. On a control-transfer flush it abandons an in-flight fetch cleanly, so the pipeline sees no stale instruction. It sits between the pipeline stages and the memory/bus interface. Each requester's `resp_valid` output feeds that stage's `pipe_ready` term.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive MEM grants tolerated while IF waits; range 1..15, used only with the guard macro

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr stable until if_resp_valid or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  one-cycle pulse; driven from exe_pc_src; cancels the fetch
- if_resp_valid  out  1  one-cycle pulse; fetch data valid
- if_rdata  out  DATA_W  fetch data
- mem_req  in  1  data request; held with its attributes stable until mem_resp_valid
- mem_we  in  1  1 = write
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_wstrb  in  DATA_W/8  byte enables
- mem_resp_valid  out  1  one-cycle pulse; read data valid or write done
- mem_rdata  out  DATA_W  read data
- bus_req  out  1  bus request; once high, stays high until bus_gnt
- bus_we, bus_addr, bus_wdata, bus_wstrb  out  as above  registered copy of the winner's attributes
- bus_gnt  in  1  bus accepts the request in the cycle it is sampled with bus_req
- bus_rvalid  in  1  bus response pulse; exactly one per accepted request
- bus_rdata  in  DATA_W  bus read data

## Operation
- State machine: IDLE, ADDR, WAIT.
- **IDLE**
  - Arbitrate among asserted requests. MEM wins over IF.
  - IF is excluded when if_flush is high in the same cycle.
  - On a winner, register owner and attributes onto the bus outputs, set bus_req=1, go to ADDR.
  - IF requests always drive bus_we=0 and bus_wstrb=0.
- **ADDR**
  - Hold bus_req and attributes.
  - On bus_gnt: clear bus_req, go to WAIT.
- **WAIT**
  - On bus_rvalid: return to IDLE.
  - In the same cycle, the owner's resp_valid = bus_rvalid, combinationally, unless the discard flag is set.
  - rdata outputs pass bus_rdata through combinationally. They are don't-care when resp_valid=0.
- **Discard flag**
  - Set by if_flush while owner=IF in ADDR or WAIT.
  - The bus transaction still completes, because bus_req is never withdrawn. The response is swallowed: if_resp_valid stays 0.
  - Cleared on entry to IDLE.
  - if_flush while owner=MEM, or in IDLE, has no effect on the flag.
- Never more than one transaction is outstanding. No bus_req is issued while in ADDR or WAIT.
- Requests are not registered internally. The requester must hold them.
- A requester dropping its req before its response is illegal, except IF via if_flush.
- **Reset (rst low, asynchronous)**
  - State returns to IDLE; discard flag and starvation counter are cleared.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - if_resp_valid=0, mem_resp_valid=0.
  - An in-flight bus transaction is abandoned; the bus is reset in the same domain.

## Timing
- Request seen in IDLE at cycle N → bus_req high from cycle N+1.
- Minimum response: bus_gnt at N+1 and bus_rvalid at N+2 → resp_valid at N+2 → next arbitration at N+3.
- Maximum throughput: one transaction per 3 cycles.
- if_flush sampled in the same cycle as bus_rvalid still suppresses that response.
- bus_gnt and bus_rvalid are never sampled in IDLE. Any that arrive there are ignored.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined**
  - A 4-bit counter increments on each MEM grant made while if_req is high and if_flush is low.
  - It clears on any IF grant, and whenever if_req is low in IDLE.
  - When the counter equals STARVE_MAX, IF wins the next IDLE arbitration even if mem_req is high.
  - The counter resets to 0.
- **Undefined**
  - No counter exists; MEM strictly wins.
  - STARVE_MAX is unused.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x1000 at N; bus_gnt at N+1; bus_rvalid at N+3 with rdata=0x00000013 → bus_addr=0x1000 and bus_req high N+1 only; if_resp_valid=1 with if_rdata=0x00000013 at N+3.
- **Simultaneous requests:** if_req and mem_req (write, addr 0x2000, wstrb 0xFF) both at N → MEM granted first with bus_we=1; IF issued at the first IDLE after the MEM response.
- **Flush while waiting:** IF owner in WAIT, if_flush pulse, bus_rvalid 2 cycles later → if_resp_valid stays 0. New if_req at addr 0x3000 is issued in the next IDLE.
- **Bus stall:** bus_gnt held low for 5 cycles → bus_req and bus_addr stable for all 5 cycles. Exactly one transaction is issued.
- **Starvation guard** (`MEM_ARB_STARVE_GUARD_EN`, STARVE_MAX=2): mem_req and if_req both held high → grant order is MEM, MEM, IF, MEM, MEM, IF. Without the macro, IF is never granted.
- **Reset in WAIT:** rst low in WAIT → all outputs 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE and a fresh request is issued normally.
